// File: rtl/serial_output_register_pkg.sv
// Shared DoubleDabble definitions: frame-state encodings and the default frame width.
// These values are common to the input register, this capture register and the converter.
package serial_output_register_pkg;

    typedef enum logic {
        DD_IDLE  = 1'b0,
        DD_SHIFT = 1'b1
    } dd_state_t;

    localparam int DD_WIDTH = 8;

endpackage

// File: rtl/serial_output_register_dd_bit_counter.sv
// Frame bit counter for the DoubleDabble serial link.
// Counts accepted bits and flags the bit that completes a WIDTH-bit frame.
module dd_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    input  logic en,
    output logic terminal
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] count;

    // The bit being accepted now is the last one of the frame.
    always_comb begin
        terminal = en && (count == CW'(WIDTH - 1));
    end

    // Count accepted bits; restart also covers the return to idle, so the count never wraps.
    always_ff @(posedge clk) begin
        if (clear || restart) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_output_register.sv
// Serial-in/parallel-out capture register, receiving end of the DoubleDabble bit stream.
// Bits arrive MSB first; completed words are held on parallel_out behind a valid/ready handshake.
// Optional feature macro: DIGIT_CHECK_EN adds the bcd_error output (any nibble above 9).
module serial_output_register
    import serial_output_register_pkg::*;
#(
    parameter int WIDTH = DD_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             serial_in,
    input  logic             shift_en,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
`ifdef DIGIT_CHECK_EN
    ,
    output logic             bcd_error
`endif
);

    dd_state_t        state;
    dd_state_t        state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;
    logic             shift_take;
    logic             frame_done;
    logic             load_word;
    logic             drop_word;

    // A bit is accepted only mid-frame and never on the cycle a start restarts the frame.
    always_comb begin
        shift_take = (state == DD_SHIFT) && shift_en && !start;
        next_word  = {shift_reg[WIDTH-2:0], serial_in};
        load_word  = frame_done && !(out_valid && !out_ready);
        drop_word  = frame_done && out_valid && !out_ready;
    end

    dd_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .clear    (clear),
        .restart  (start || frame_done),
        .en       (shift_take),
        .terminal (frame_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= DD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start always (re)opens a frame, the final bit closes it.
    always_comb begin
        state_next = state;
        case (state)
            DD_IDLE: begin
                if (start) begin
                    state_next = DD_SHIFT;
                end
            end
            DD_SHIFT: begin
                if (start) begin
                    state_next = DD_SHIFT;
                end else if (frame_done) begin
                    state_next = DD_IDLE;
                end
            end
            default: state_next = DD_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state == DD_SHIFT);
    end

    // Shift register; a start throws away any partial frame.
    always_ff @(posedge clk) begin
        if (clear || start) begin
            shift_reg <= '0;
        end else if (shift_take) begin
            shift_reg <= next_word;
        end
    end

    // Output buffer: load when the slot is free or being consumed this same edge, else drop.
    always_ff @(posedge clk) begin
        if (clear) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load_word) begin
                parallel_out <= next_word;
                out_valid    <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid    <= 1'b0;
            end
            if (drop_word) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef DIGIT_CHECK_EN
    logic next_bad_digit;

    // Flag any nibble of the incoming word that is not a decimal digit.
    always_comb begin
        next_bad_digit = 1'b0;
        for (int i = 0; i < WIDTH / 4; i++) begin
            if (next_word[i*4 +: 4] > 4'd9) begin
                next_bad_digit = 1'b1;
            end
        end
    end

    // Digit-check flag tracks the word currently held on parallel_out.
    always_ff @(posedge clk) begin
        if (clear) begin
            bcd_error <= 1'b0;
        end else if (load_word) begin
            bcd_error <= next_bad_digit;
        end
    end
`endif

endmodule

// File: tb/tb_serial_output_register.sv
// Directed bench for serial_output_register with a scoreboard of expected loaded words.
module tb_serial_output_register;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic       serial_in = 1'b0;
    logic       shift_en = 1'b0;
    logic [7:0] parallel_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       overrun;
`ifdef DIGIT_CHECK_EN
    logic       bcd_error;
`endif

    logic [7:0] sb_q[$];
    int         n_compared = 0;
    int         n_mismatched = 0;

    serial_output_register #(
        .WIDTH (8)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .start        (start),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .overrun      (overrun)
`ifdef DIGIT_CHECK_EN
        ,
        .bcd_error    (bcd_error)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pop the next expected word and compare it against parallel_out.
    task automatic check_word(input string tag);
        logic [7:0] exp_word;
        if (sb_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected <scoreboard empty>", tag, parallel_out);
        end else begin
            exp_word = sb_q.pop_front();
            check_output(tag, {24'd0, parallel_out}, {24'd0, exp_word});
        end
    endtask

    // Send one frame: start pulse, then 8 bits MSB first with an optional gap before bit 4.
    task automatic send_frame(input logic [7:0] w, input int gap_len,
                              input logic ready_last, input logic expect_load);
        if (expect_load) sb_q.push_back(w);
        start = 1'b1;
        shift_en = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                for (int g = 0; g < gap_len; g++) begin
                    shift_en = 1'b0;
                    serial_in = 1'b1;
                    step();
                end
            end
            shift_en = 1'b1;
            serial_in = w[7-i];
            out_ready = (i == 7) ? ready_last : 1'b0;
            step();
        end
        shift_en = 1'b0;
        serial_in = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic accept_word();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] restart_word;
        restart_word = 8'h3C;

        // Power-up reset.
        step();
        step();
        clear = 1'b0;
        check_output("reset_parallel_out", {24'd0, parallel_out}, 32'h0);
        check_output("reset_out_valid", {31'd0, out_valid}, 32'h0);
        check_output("reset_busy", {31'd0, busy}, 32'h0);
        check_output("reset_overrun", {31'd0, overrun}, 32'h0);
`ifdef DIGIT_CHECK_EN
        check_output("reset_bcd_error", {31'd0, bcd_error}, 32'h0);
`endif

        // Clear in the middle of a frame discards it.
        start = 1'b1;
        step();
        start = 1'b0;
        shift_en = 1'b1;
        serial_in = 1'b1;
        step();
        step();
        check_output("midframe_busy", {31'd0, busy}, 32'h1);
        shift_en = 1'b0;
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;
        check_output("midclear_busy", {31'd0, busy}, 32'h0);
        check_output("midclear_out_valid", {31'd0, out_valid}, 32'h0);
        check_output("midclear_parallel_out", {24'd0, parallel_out}, 32'h0);
        check_output("midclear_overrun", {31'd0, overrun}, 32'h0);

        // shift_en without start is ignored.
        shift_en = 1'b1;
        serial_in = 1'b1;
        step();
        step();
        step();
        shift_en = 1'b0;
        check_output("idle_busy", {31'd0, busy}, 32'h0);
        check_output("idle_out_valid", {31'd0, out_valid}, 32'h0);

        // Basic frame, consumer not ready.
        send_frame(8'hAF, 0, 1'b0, 1'b1);
        check_word("basic_word");
        check_output("basic_out_valid", {31'd0, out_valid}, 32'h1);
        check_output("basic_busy", {31'd0, busy}, 32'h0);
        check_output("basic_overrun", {31'd0, overrun}, 32'h0);
        accept_word();
        check_output("accept_out_valid", {31'd0, out_valid}, 32'h0);
        check_output("accept_hold", {24'd0, parallel_out}, 32'hAF);

        // Gapped frame and handshake.
        send_frame(8'h12, 3, 1'b0, 1'b1);
        check_word("gapped_word");
        check_output("gapped_out_valid", {31'd0, out_valid}, 32'h1);
        accept_word();
        check_output("gapped_accept_valid", {31'd0, out_valid}, 32'h0);
        check_output("gapped_accept_hold", {24'd0, parallel_out}, 32'h12);

        // Overrun: second word dropped while first is still pending.
        send_frame(8'hAF, 0, 1'b0, 1'b1);
        check_word("pre_overrun_word");
        check_output("pre_overrun_flag", {31'd0, overrun}, 32'h0);
        send_frame(8'h55, 0, 1'b0, 1'b0);
        check_output("overrun_hold", {24'd0, parallel_out}, 32'hAF);
        check_output("overrun_out_valid", {31'd0, out_valid}, 32'h1);
        check_output("overrun_flag", {31'd0, overrun}, 32'h1);
        accept_word();
        send_frame(8'h81, 0, 1'b0, 1'b1);
        check_word("post_overrun_word");
        check_output("overrun_sticky", {31'd0, overrun}, 32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_output("overrun_cleared", {31'd0, overrun}, 32'h0);
        check_output("clear_out_valid", {31'd0, out_valid}, 32'h0);
        check_output("clear_parallel_out", {24'd0, parallel_out}, 32'h0);

        // Restart mid-frame; the bit coinciding with the second start is discarded.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            shift_en = 1'b1;
            serial_in = 1'b1;
            step();
        end
        sb_q.push_back(restart_word);
        start = 1'b1;
        shift_en = 1'b1;
        serial_in = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            serial_in = restart_word[7-i];
            step();
            if (i == 6) begin
                check_output("restart_busy_7bits", {31'd0, busy}, 32'h1);
                check_output("restart_valid_7bits", {31'd0, out_valid}, 32'h0);
            end
        end
        shift_en = 1'b0;
        serial_in = 1'b0;
        check_word("restart_word");
        check_output("restart_out_valid", {31'd0, out_valid}, 32'h1);
        check_output("restart_overrun", {31'd0, overrun}, 32'h0);
`ifdef DIGIT_CHECK_EN
        check_output("bcd_3c", {31'd0, bcd_error}, 32'h1);
`endif

        // Same-edge accept of the old word and load of the new one.
        send_frame(8'h39, 0, 1'b1, 1'b1);
        check_word("swap_word");
        check_output("swap_out_valid", {31'd0, out_valid}, 32'h1);
        check_output("swap_overrun", {31'd0, overrun}, 32'h0);
`ifdef DIGIT_CHECK_EN
        check_output("bcd_39", {31'd0, bcd_error}, 32'h0);
`endif
        accept_word();
        send_frame(8'h3A, 0, 1'b0, 1'b1);
        check_word("word_3a");
`ifdef DIGIT_CHECK_EN
        check_output("bcd_3a", {31'd0, bcd_error}, 32'h1);
`endif
        check_output("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
